// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - shared RISC-TOY widths, opcodes and fetch-queue entry
package risc_toy_pkg;

   localparam int IAW = 30;
   localparam int IW  = 32;

   typedef enum logic [4:0] {
      OP_ADDI = 5'd0,
      OP_ANDI = 5'd1,
      OP_ORI  = 5'd2,
      OP_MOVI = 5'd3,
      OP_ADD  = 5'd4,
      OP_SUB  = 5'd5,
      OP_NEG  = 5'd6,
      OP_NOT  = 5'd7,
      OP_AND  = 5'd8,
      OP_OR   = 5'd9,
      OP_XOR  = 5'd10,
      OP_LSR  = 5'd11,
      OP_ASR  = 5'd12,
      OP_SHL  = 5'd13,
      OP_ROR  = 5'd14,
      OP_BR   = 5'd15,
      OP_BRL  = 5'd16,
      OP_J    = 5'd17,
      OP_JL   = 5'd18,
      OP_LD   = 5'd19,
      OP_LDR  = 5'd20,
      OP_ST   = 5'd21,
      OP_STR  = 5'd22
   } opcode_e;

   typedef struct packed {
      logic [IAW-1:0] pc;
      logic [IW-1:0]  instr;
   } ifq_entry_t;

endpackage

// File: rtl/risc_toy_ifq.sv
// rtl/risc_toy_ifq.sv - fetch instruction queue, power-of-two ring buffer with flush
module risc_toy_ifq
   import risc_toy_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  ifq_entry_t             i_data,
   output logic [$clog2(DEPTH):0] o_count,
   output ifq_entry_t             o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   ifq_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign w_pop   = i_pop && (r_count != '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_head];

   // Storage is cleared on reset so the head outputs are never X.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_data;
            r_tail        <= r_tail + 1'b1;
         end
         if (w_pop) r_head <= r_head + 1'b1;
         if (i_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!i_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && !i_flush && i_push)
         assert (r_count < FULL);
   end

endmodule

// File: rtl/risc_toy_fetch.sv
// rtl/risc_toy_fetch.sv - RISC-TOY fetch PC, in-flight tracking and queue credit
module risc_toy_fetch
   import risc_toy_pkg::*;
#(
   parameter int             DEPTH    = 4,
   parameter logic [IAW-1:0] RESET_PC = '0
) (
   input  logic           CLK,
   input  logic           RST,
   output logic           IREQ,
   output logic [IAW-1:0] IADDR,
   input  logic [IW-1:0]  INSTR,
   input  logic           REDIR,
   input  logic [IAW-1:0] REDIR_ADDR,
   output logic           ID_VALID,
   input  logic           ID_READY,
   output logic [IW-1:0]  ID_INSTR,
   output logic [IAW-1:0] ID_PC
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   logic [IAW-1:0] r_fpc;
   logic [IAW-1:0] r_inflight_pc;
   logic           r_inflight;
   logic [CW-1:0]  w_count;
   logic           w_issue;
   logic           w_push;
   logic           w_pop;
   ifq_entry_t     w_push_data;
   ifq_entry_t     w_head;

   // Credit ignores a same-cycle pop; the slot it frees is reused one cycle later.
   assign w_issue = !RST && !REDIR &&
                    (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < CREDITS);

   assign w_push      = r_inflight && !REDIR;
   assign w_pop       = ID_VALID && ID_READY && !REDIR;
   assign w_push_data = '{pc: r_inflight_pc, instr: INSTR};

   assign IREQ     = w_issue;
   assign IADDR    = r_fpc;
   assign ID_VALID = (w_count != '0);
   assign ID_INSTR = w_head.instr;
   assign ID_PC    = w_head.pc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fpc         <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (REDIR) begin
         r_fpc      <= REDIR_ADDR;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fpc         <= r_fpc + 1'b1;
            r_inflight_pc <= r_fpc;
         end
      end
   end

   risc_toy_ifq #(
      .DEPTH (DEPTH)
   ) u_ifq (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (REDIR),
      .i_data  (w_push_data),
      .o_count (w_count),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_risc_toy_fetch.sv
// tb/tb_risc_toy_fetch.sv - scoreboard bench for risc_toy_fetch
`timescale 1ns/1ps
module tb_risc_toy_fetch;
   import risc_toy_pkg::*;

   localparam logic [IAW-1:0] WRAP_PC = 30'h3FFFFFFE;
   localparam logic [IW-1:0]  JUNK    = 32'hDEADBEEF;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           IREQ;
   logic [IAW-1:0] IADDR;
   logic [IW-1:0]  INSTR = '0;
   logic           REDIR = 1'b0;
   logic [IAW-1:0] REDIR_ADDR = '0;
   logic           ID_VALID;
   logic           ID_READY = 1'b1;
   logic [IW-1:0]  ID_INSTR;
   logic [IAW-1:0] ID_PC;

   logic           b_ireq;
   logic [IAW-1:0] b_iaddr;
   logic [IW-1:0]  b_instr = '0;
   logic           b_redir = 1'b0;
   logic [IAW-1:0] b_redir_addr = '0;
   logic           b_valid;
   logic           b_ready = 1'b1;
   logic [IW-1:0]  b_id_instr;
   logic [IAW-1:0] b_pc;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   int outstanding = 0;

   typedef struct packed {
      logic [IAW-1:0] pc;
      logic [IW-1:0]  instr;
   } exp_t;

   exp_t           exp_q[$];
   logic [IAW-1:0] model_next;

   risc_toy_fetch #(.DEPTH(4), .RESET_PC(30'h0)) u_dut (
      .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
      .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR), .ID_VALID(ID_VALID),
      .ID_READY(ID_READY), .ID_INSTR(ID_INSTR), .ID_PC(ID_PC)
   );

   risc_toy_fetch #(.DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
      .CLK(CLK), .RST(RST), .IREQ(b_ireq), .IADDR(b_iaddr), .INSTR(b_instr),
      .REDIR(b_redir), .REDIR_ADDR(b_redir_addr), .ID_VALID(b_valid),
      .ID_READY(b_ready), .ID_INSTR(b_id_instr), .ID_PC(b_pc)
   );

   always #5 CLK = ~CLK;

   function automatic logic [IW-1:0] mem_word(input logic [IAW-1:0] a);
      return {~a[1:0], a} ^ {a[14:0], 17'h0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back('{pc: model_next, instr: mem_word(model_next)});
         model_next = model_next + 1'b1;
      end
   endtask

   task automatic sb_restart(input logic [IAW-1:0] a);
      exp_q.delete();
      model_next = a;
      sb_top_up();
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Memory: each request is answered during the following cycle.
   initial begin
      logic           a_req, b_req;
      logic [IAW-1:0] a_addr, b_addr;
      forever begin
         @(negedge CLK);
         a_req = IREQ;   a_addr = IADDR;
         b_req = b_ireq; b_addr = b_iaddr;
         @(posedge CLK);
         #1;
         INSTR   = a_req ? mem_word(a_addr) : JUNK;
         b_instr = b_req ? mem_word(b_addr) : JUNK;
      end
   end

   // Monitor: compare every accepted head against the expected stream.
   initial begin
      exp_t e;
      logic popped;
      forever begin
         @(negedge CLK);
         popped = !RST && ID_VALID && ID_READY && !REDIR;
         if (popped) begin
            e = exp_q.pop_front();
            chk("stream_pc", 64'(ID_PC), 64'(e.pc));
            chk("stream_instr", 64'(ID_INSTR), 64'(e.instr));
            pops++;
            sb_top_up();
         end
         if (RST || REDIR) outstanding = 0;
         else outstanding = outstanding + int'(IREQ) - int'(popped);
         chk("credit_bound", 64'(outstanding <= 4), 64'd1);
      end
   end

   initial begin
      int             n;
      int             pops0;
      logic [IAW-1:0] last;
      logic [IAW-1:0] ea;

      sb_restart('0);
      repeat (3) tick();
      #1;
      chk("rst_ireq", 64'(IREQ), 64'd0);
      chk("rst_iaddr", 64'(IADDR), 64'd0);
      chk("rst_valid", 64'(ID_VALID), 64'd0);
      chk("rst_instr", 64'(ID_INSTR), 64'd0);
      chk("rst_pc", 64'(ID_PC), 64'd0);
      chk("rst_wrap_iaddr", 64'(b_iaddr), 64'(WRAP_PC));

      // Streaming from reset, plus the wrapping instance alongside.
      tick(); RST = 1'b0; ID_READY = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         #1;
         chk("t1_ireq", 64'(IREQ), 64'd1);
         chk("t1_iaddr", 64'(IADDR), 64'(k));
         chk("t1_valid", 64'(ID_VALID), 64'(k >= 2));
         chk("wrap_valid", 64'(b_valid), 64'(k >= 2));
         if (k < 4) begin
            ea = WRAP_PC + IAW'(k);
            chk("wrap_iaddr", 64'(b_iaddr), 64'(ea));
         end
         if (k >= 2 && k < 6) begin
            ea = WRAP_PC + IAW'(k - 2);
            chk("wrap_pc", 64'(b_pc), 64'(ea));
            chk("wrap_instr", 64'(b_id_instr), 64'(mem_word(ea)));
         end
      end

      // Decode stalled from reset: queue fills, then one pop frees one fetch.
      tick(); RST = 1'b1; sb_restart('0);
      tick(); tick(); RST = 1'b0; ID_READY = 1'b0;
      n = 0; last = '0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         #1;
         if (IREQ) begin n++; last = IADDR; end
      end
      chk("t2_ireq_count", 64'(n), 64'd4);
      chk("t2_last_addr", 64'(last), 64'd3);
      chk("t2_head_pc", 64'(ID_PC), 64'd0);
      chk("t2_valid", 64'(ID_VALID), 64'd1);
      tick(); ID_READY = 1'b1; #1;
      chk("t2_pulse_ireq", 64'(IREQ), 64'd0);
      tick(); ID_READY = 1'b0; #1;
      chk("t2_refill_ireq", 64'(IREQ), 64'd1);
      chk("t2_refill_addr", 64'(IADDR), 64'd4);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         tick(); #1;
         if (IREQ) n++;
      end
      chk("t2_after_count", 64'(n), 64'd0);
      chk("t2_head_after", 64'(ID_PC), 64'd1);

      // Redirect while streaming, with a response in flight and a pop offered.
      tick(); RST = 1'b1; sb_restart('0);
      tick(); tick(); RST = 1'b0; ID_READY = 1'b1;
      for (int k = 1; k < 10; k++) tick();
      tick();
      REDIR = 1'b1; REDIR_ADDR = 30'h100; sb_restart(30'h100); #1;
      chk("t3_ireq_T", 64'(IREQ), 64'd0);
      tick(); REDIR = 1'b0; #1;
      chk("t3_ireq_T1", 64'(IREQ), 64'd1);
      chk("t3_iaddr_T1", 64'(IADDR), 64'h100);
      chk("t3_valid_T1", 64'(ID_VALID), 64'd0);
      tick(); #1;
      chk("t3_valid_T2", 64'(ID_VALID), 64'd0);
      tick(); #1;
      chk("t3_valid_T3", 64'(ID_VALID), 64'd1);
      chk("t3_pc_T3", 64'(ID_PC), 64'h100);
      repeat (5) tick();

      // Back-to-back redirects: the second target wins.
      REDIR = 1'b1; REDIR_ADDR = 30'h200; sb_restart(30'h200);
      tick(); REDIR_ADDR = 30'h300; sb_restart(30'h300);
      tick(); REDIR = 1'b0; #1;
      chk("b2b_iaddr", 64'(IADDR), 64'h300);
      chk("b2b_ireq", 64'(IREQ), 64'd1);
      tick(); #1;
      chk("b2b_valid_early", 64'(ID_VALID), 64'd0);
      tick(); #1;
      chk("b2b_valid", 64'(ID_VALID), 64'd1);
      chk("b2b_pc", 64'(ID_PC), 64'h300);

      // Asynchronous reset with three entries buffered.
      tick(); RST = 1'b1; sb_restart('0);
      tick(); tick(); RST = 1'b0; ID_READY = 1'b0;
      repeat (4) tick();
      #1;
      chk("t4_valid_pre", 64'(ID_VALID), 64'd1);
      RST = 1'b1; sb_restart('0); #1;
      chk("t4_async_valid", 64'(ID_VALID), 64'd0);
      chk("t4_async_ireq", 64'(IREQ), 64'd0);
      tick(); tick(); RST = 1'b0; ID_READY = 1'b1; #1;
      chk("t4_restart_ireq", 64'(IREQ), 64'd1);
      chk("t4_restart_iaddr", 64'(IADDR), 64'd0);

      // Random decode back-pressure and redirects.
      pops0 = pops;
      for (int c = 0; c < 800; c++) begin
         tick();
         ID_READY = ($urandom_range(3) != 0);
         if ($urandom_range(24) == 0) begin
            REDIR = 1'b1;
            if ($urandom_range(1) == 1) REDIR_ADDR = 30'($urandom);
            else REDIR_ADDR = 30'h3FFFFFFC + 30'($urandom_range(3));
            sb_restart(REDIR_ADDR);
         end else begin
            REDIR = 1'b0;
         end
         #1;
         if (REDIR) chk("rnd_redir_ireq", 64'(IREQ), 64'd0);
      end
      tick(); REDIR = 1'b0; ID_READY = 1'b1;
      repeat (10) tick();
      chk("rnd_progress", 64'((pops - pops0) > 300), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
